// File: rtl/mem_access_wb_reg.sv
// MEM-stage data memory (byte/half/word, little-endian) and MEM/WB pipeline register.
// Load data is aligned and extended combinationally, then registered with the writeback control.
module mem_access_wb_reg #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [1:0]  msize,
    input  logic        munsigned,
    input  logic [4:0]  mrn,
    input  logic [31:0] mr,
    input  logic [31:0] mqb,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [4:0]  wrn,
    output logic [31:0] wr,
    output logic [31:0] wdo,
    output logic        wexc
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       ram_q [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic              is_mem;
    logic              mis;
    logic              do_store;
    logic [3:0]        be;
    logic [31:0]       rd_word;
    logic [31:0]       st_data;
    logic [31:0]       wr_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;
    logic              unused_addr;

    logic        wwreg_q,  wwreg_d;
    logic        wm2reg_q, wm2reg_d;
    logic [4:0]  wrn_q,    wrn_d;
    logic [31:0] wr_q,     wr_d;
    logic [31:0] wdo_q,    wdo_d;
    logic        wexc_q,   wexc_d;

    // Address bits above the RAM depth are ignored, so accesses wrap.
    assign unused_addr = ^mr[31:ADDR_W+2];

    // NOTE: every signal gets a default at the top of always_comb so no latch can be inferred.
    always_comb begin
        word_idx = mr[ADDR_W+1:2];
        lane     = mr[1:0];
        rd_word  = ram_q[word_idx];
        is_mem   = mwmem | mm2reg;
        mis      = 1'b0;
        be       = 4'b1111;
        st_data  = mqb;
        ld_byte  = rd_word[{lane, 3'b000} +: 8];
        ld_half  = mr[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data  = rd_word;
        case (msize)
            2'b00: begin
                be      = 4'b0001 << lane;
                st_data = {4{mqb[7:0]}};
                ld_data = {{24{~munsigned & ld_byte[7]}}, ld_byte};
            end
            2'b01: begin
                mis     = is_mem & mr[0];
                be      = mr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{mqb[15:0]}};
                ld_data = {{16{~munsigned & ld_half[15]}}, ld_half};
            end
            default: begin
                mis = is_mem & (lane != 2'b00);
            end
        endcase
        // Lanes not enabled keep the word's current contents.
        for (int k = 0; k < 4; k++) begin
            wr_word[8*k +: 8] = be[k] ? st_data[8*k +: 8] : rd_word[8*k +: 8];
        end
        do_store = mwmem & ~mis & ~rst & ~stall & ~flush;
    end

    // NOTE: the RAM array has no reset; clearing it would defeat RAM inference.
    always_ff @(posedge clk) begin
        if (do_store) begin
            ram_q[word_idx] <= wr_word;
        end
    end

    always_comb begin
        wwreg_d  = wwreg_q;
        wm2reg_d = wm2reg_q;
        wrn_d    = wrn_q;
        wr_d     = wr_q;
        wdo_d    = wdo_q;
        wexc_d   = wexc_q;
        if (flush) begin
            wwreg_d  = 1'b0;
            wm2reg_d = 1'b0;
            wrn_d    = '0;
            wr_d     = '0;
            wdo_d    = '0;
            wexc_d   = 1'b0;
        end else if (!stall) begin
            // A store never writes back, even if mm2reg is also set.
            wwreg_d  = mwreg & ~mwmem & ~mis;
            wm2reg_d = mm2reg & ~mwmem & ~mis;
            wrn_d    = mrn;
            wr_d     = mr;
            wdo_d    = (mm2reg & ~mwmem & ~mis) ? ld_data : 32'd0;
            wexc_d   = mis;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wwreg_q  <= 1'b0;
            wm2reg_q <= 1'b0;
            wrn_q    <= '0;
            wr_q     <= '0;
            wdo_q    <= '0;
            wexc_q   <= 1'b0;
        end else begin
            wwreg_q  <= wwreg_d;
            wm2reg_q <= wm2reg_d;
            wrn_q    <= wrn_d;
            wr_q     <= wr_d;
            wdo_q    <= wdo_d;
            wexc_q   <= wexc_d;
        end
    end

    assign wwreg  = wwreg_q;
    assign wm2reg = wm2reg_q;
    assign wrn    = wrn_q;
    assign wr     = wr_q;
    assign wdo    = wdo_q;
    assign wexc   = wexc_q;

endmodule

// File: doc/mem_access_wb_reg.md
Name: mem_access_wb_reg

Overview:
MEM-stage data memory plus the MEM/WB pipeline register for the 5-stage MIPS core. It performs byte, halfword and word loads and stores on an internal word-organised data RAM, and aligns and extends load data. It registers the ALU result, load data and writeback control into the WB stage. Its outputs wr, wdo and wm2reg drive the writeback mux directly; wwreg and wrn go to the register file.

Parameters:
ADDR_W, 8, word-address width; RAM depth = 2**ADDR_W 32-bit words
Little-endian byte order is fixed; it is not a parameter.

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold the MEM/WB register; suppress the store
flush  in  1  turn the MEM-stage instruction into a bubble; suppress the store
mwreg  in  1  MEM-stage register-write enable
mm2reg  in  1  MEM-stage load (writeback selects memory data)
mwmem  in  1  MEM-stage store enable
msize  in  2  00 byte, 01 half, 10 word, 11 treated as word
munsigned  in  1  1 = zero-extend loads (lbu/lhu), 0 = sign-extend
mrn  in  5  destination register number
mr  in  32  ALU result / effective byte address
mqb  in  32  store data (low bits used for byte/half)
wwreg  out  1  WB register-write enable
wm2reg  out  1  WB select: 1 = wdo, 0 = wr
wrn  out  5  WB destination register
wr  out  32  registered ALU result
wdo  out  32  registered, aligned, extended load data
wexc  out  1  misaligned-access flag for the instruction now in WB

Behaviour:
- Address decode: word index = mr[ADDR_W+1:2]. Upper bits are ignored, so out-of-range addresses wrap. Byte lane k = mr[1:0] selects bits [8k+7:8k].
- Misaligned access (mis): half with mr[0]=1, or word/size-11 with mr[1:0]!=0. Byte accesses are never misaligned.
- Store: the RAM is written at a rising edge only when mwmem=1, rst=0, stall=0, flush=0 and mis=0. Byte and half stores update only their lanes (half: lanes 0-1 if mr[1]=0, else lanes 2-3). Other lanes are preserved.
- Load extraction is combinational on the current RAM contents: byte/half are right-justified, then sign- or zero-extended per munsigned; word passes through unchanged. The result is registered into wdo.
- Load latency: wdo is valid in the cycle after the instruction is in MEM, together with wr, wrn, wwreg and wm2reg.
- Store then load to the same word in the next cycle returns the new data.
- mwmem and mm2reg both 1: treated as a store. The captured wm2reg=0 and wwreg=0.
- Misaligned instruction: no RAM write; captured wdo=0, wwreg=0, wm2reg=0, wexc=1 for exactly that WB cycle. wr and wrn are captured normally.
- Normal capture (rst=0, flush=0, stall=0):
  - wwreg and wm2reg as gated above.
  - wrn=mrn, wr=mr, wexc=mis.
  - wdo = extracted load data when mm2reg=1 (and not a store or misaligned), else 0.
- Priority, highest first:
  - rst: all outputs 0.
  - flush: bubble; all outputs 0, no store.
  - stall: all outputs hold their values, no store.
  - normal capture.
- Reset: wwreg=0, wm2reg=0, wrn=0, wr=0, wdo=0, wexc=0. RAM contents are NOT cleared; their power-up value is undefined, so the bench writes before it reads. Reset asserted mid-stream discards the in-flight MEM instruction, including its store.
- No stores occur in a cycle where rst=1.
- The RAM is inferred as a single-port, write-first array. Its read is asynchronous within the cycle.

Test Plan:
- sw mqb=0x89ABCDEF @mr=0x10, then lw @0x10 -> next-cycle wdo=0x89ABCDEF, wm2reg=1, wwreg=1, wrn=mrn, wexc=0.
- With word 0x89ABCDEF @0x10: lb @0x13 -> wdo=0xFFFFFF89; lbu @0x13 -> 0x00000089; lh @0x10 -> 0xFFFFCDEF; lhu @0x12 -> 0x000089AB.
- sb mqb=0x00000055 @0x11 over 0x89ABCDEF, then lw @0x10 -> 0x89AB55EF; sh mqb=0x1234 @0x12 -> lw gives 0x123455EF.
- lw @0x12 or sh @0x11 -> wexc=1, wwreg=0, wm2reg=0, wdo=0 for one cycle; a follow-up lw shows the RAM word unchanged.
- stall=1 held 3 cycles with a sw pending -> outputs frozen and RAM unchanged; after release, the store commits once.
- flush=1 on a sw, or rst=1 on a sw -> all outputs 0 next cycle and the RAM word unchanged. ALU op (mwreg=1, mm2reg=0, mr=0xDEADBEEF, mrn=7) -> wr=0xDEADBEEF, wrn=7, wm2reg=0, wdo=0.
